// File: rtl/wbuf_loader.sv
// Weight-buffer loader: turns a (base row, row count) command plus a beat stream
// into bank-by-bank weight-buffer writes, one registered write per accepted beat.
module wbuf_loader #(
    parameter int MEM_DATA_WIDTH = 64,
    parameter int ARRAY_N        = 64,
    parameter int ARRAY_M        = 64,
    parameter int DATA_WIDTH     = 16,
    parameter int BUF_ADDR_WIDTH = 9,
    localparam int GROUP_SIZE     = (DATA_WIDTH * ARRAY_M) / MEM_DATA_WIDTH,
    localparam int NUM_BANKS      = ARRAY_N * GROUP_SIZE,
    localparam int BUF_ID_W       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0,
    localparam int MEM_ADDR_WIDTH = BUF_ADDR_WIDTH + BUF_ID_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [BUF_ADDR_WIDTH-1:0] cmd_base_addr,
    input  logic [BUF_ADDR_WIDTH:0]   cmd_num_rows,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [MEM_DATA_WIDTH-1:0] s_data,
    input  logic                      s_last,
    output logic                      mem_write_req,
    output logic [MEM_ADDR_WIDTH-1:0] mem_write_addr,
    output logic [MEM_DATA_WIDTH-1:0] mem_write_data,
    output logic                      busy,
    output logic                      done,
    output logic                      last_err
);
    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // cmd_ready is high only in IDLE, s_ready only in LOAD, neither depends on valid.
    localparam int BANK_CW = (BUF_ID_W > 0) ? BUF_ID_W : 1;
    localparam int ROW_W   = BUF_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

    state_t                    state, state_nxt;
    logic [BUF_ADDR_WIDTH-1:0] base_q;
    logic [ROW_W-1:0]          num_rows_q;
    logic [ROW_W-1:0]          row_cnt;
    logic [BANK_CW-1:0]        bank_cnt;
    logic                      cmd_fire;
    logic                      beat_fire;
    logic                      bank_wrap;
    logic                      final_beat;
    logic [BUF_ADDR_WIDTH-1:0] row_addr;
    logic [MEM_ADDR_WIDTH-1:0] wr_addr;

    assign cmd_fire   = cmd_valid && (state == IDLE);
    assign beat_fire  = s_valid && (state == LOAD);
    assign bank_wrap  = (bank_cnt == BANK_CW'(NUM_BANKS - 1));
    assign final_beat = bank_wrap && ((row_cnt + ROW_W'(1)) == num_rows_q);
    // Row address wraps silently at the top of the buffer.
    assign row_addr   = base_q + row_cnt[BUF_ADDR_WIDTH-1:0];

    if (BUF_ID_W > 0) begin : g_banked
        assign wr_addr = {row_addr, bank_cnt};
    end else begin : g_single
        assign wr_addr = row_addr;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        s_ready   = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_nxt = (cmd_num_rows == '0) ? FLUSH : LOAD;
            end
            LOAD: begin
                s_ready = 1'b1;
                if (beat_fire && final_beat) state_nxt = FLUSH;
            end
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q         <= '0;
            num_rows_q     <= '0;
            row_cnt        <= '0;
            bank_cnt       <= '0;
            mem_write_req  <= 1'b0;
            mem_write_addr <= '0;
            mem_write_data <= '0;
            done           <= 1'b0;
            last_err       <= 1'b0;
        end else begin
            mem_write_req <= beat_fire;
            // FLUSH always returns to IDLE, so done lands in the first IDLE cycle.
            done          <= (state == FLUSH);
            if (cmd_fire) begin
                base_q     <= cmd_base_addr;
                num_rows_q <= cmd_num_rows;
                row_cnt    <= '0;
                bank_cnt   <= '0;
                last_err   <= 1'b0;
            end
            if (beat_fire) begin
                mem_write_addr <= wr_addr;
                mem_write_data <= s_data;
                if (bank_wrap) begin
                    bank_cnt <= '0;
                    row_cnt  <= row_cnt + ROW_W'(1);
                end else begin
                    bank_cnt <= bank_cnt + BANK_CW'(1);
                end
                if (s_last != final_beat) last_err <= 1'b1;
            end
        end
    end
endmodule
